// File: rtl/spi_ctrl_pkg.sv
// rtl/spi_ctrl_pkg.sv - Opcodes, FSM states and shared widths for the SPI command sequencer
package spi_ctrl_pkg;

    localparam int CMD_W = 8;

    typedef enum logic [CMD_W-1:0] {
        CONF_WR      = 8'h2a,
        CHAN_SEL     = 8'h2b,
        ERR_CLR      = 8'h2f,
        INFO_RD      = 8'h3a,
        DATA_RD      = 8'h3b,
        DATA_RD_CONT = 8'h3c
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        CONF,
        CHAN,
        INFO,
        DATA,
        DCONT
    } state_t;

endpackage

// File: rtl/rd_addr_gen.sv
// rtl/rd_addr_gen.sv - Read address generator: loads a window base, steps, terminates to 0 or wraps
module rd_addr_gen #(
    parameter int RD_AW = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [RD_AW-1:0] i_base,
    input  logic [RD_AW-1:0] i_len,
    input  logic             i_step,
    input  logic             i_wrap,
    output logic [RD_AW-1:0] o_addr,
    output logic             o_last
);

    logic [RD_AW-1:0] r_addr;
    logic [RD_AW-1:0] r_start;
    logic [RD_AW-1:0] r_end;
    logic             w_last;

    assign w_last = (r_addr == r_end);

    // The window end is latched at load so stepping never re-evaluates the base arithmetic.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr  <= '0;
            r_start <= '0;
            r_end   <= '0;
        end else if (i_load) begin
            r_addr  <= i_base;
            r_start <= i_base;
            r_end   <= i_base + i_len - 1'b1;
        end else if (i_step) begin
            if (w_last) begin
                r_addr <= i_wrap ? r_start : '0;
            end else begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign o_addr = r_addr;
    assign o_last = w_last;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// rtl/spi_cmd_ctrl.sv - SPI command/address sequencer feeding the register file
// Optional sticky error flag and error counter enabled by SPI_CMD_CTRL_ERR_EN.
module spi_cmd_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int  CONF_NUM  = 4,
    parameter int  INFO_LEN  = 7,
    parameter int  DATA_BASE = 8,
    parameter int  DATA_LEN  = 11,
    parameter int  NUM_CH    = 1,
    parameter int  RD_AW     = 5,
    localparam int WA_W      = (CONF_NUM > 1) ? $clog2(CONF_NUM) : 1,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              dc_i,
    input  logic              spi_byte_vld_i,
    input  logic [CMD_W-1:0]  spi_byte_data_i,
    output logic              reg_wr_en_o,
    output logic [WA_W-1:0]   reg_wr_addr_o,
    output logic [RD_AW-1:0]  reg_rd_addr_o,
    output logic [CH_W-1:0]   chan_o,
    output logic              busy_o,
    output logic              cmd_err_o
`ifdef SPI_CMD_CTRL_ERR_EN
    ,
    output logic [7:0]        err_cnt_o
`endif
);

    localparam logic [WA_W-1:0]  CONF_LAST   = WA_W'(CONF_NUM - 1);
    localparam logic [RD_AW-1:0] INFO_LEN_A  = RD_AW'(INFO_LEN);
    localparam logic [RD_AW-1:0] DATA_LEN_A  = RD_AW'(DATA_LEN);
    localparam logic [RD_AW-1:0] DATA_BASE_A = RD_AW'(DATA_BASE);

    if (DATA_BASE + NUM_CH * DATA_LEN - 1 >= (1 << RD_AW)) begin : g_rd_aw_chk
        $error("RD_AW too narrow for the last data window");
    end
    if (DATA_BASE < INFO_LEN || CONF_NUM < 1 || NUM_CH < 1) begin : g_param_chk
        $error("inconsistent spi_cmd_ctrl window parameters");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WA_W-1:0]  r_wr_addr;
    logic [WA_W-1:0]  w_wr_addr_nxt;
    logic [CH_W-1:0]  r_chan;
    logic [CH_W-1:0]  w_chan_nxt;

    logic             w_rd_load;
    logic [RD_AW-1:0] w_rd_base;
    logic [RD_AW-1:0] w_rd_len;
    logic             w_rd_step;
    logic             w_rd_wrap;
    logic [RD_AW-1:0] w_rd_addr;
    logic             w_rd_last;
    logic [RD_AW-1:0] w_data_base;
`ifdef SPI_CMD_CTRL_ERR_EN
    logic             w_err_evt;
    logic             w_err_clr;
`endif

    assign w_data_base = DATA_BASE_A + RD_AW'(r_chan) * DATA_LEN_A;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= IDLE;
            r_wr_addr <= '0;
            r_chan    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_chan    <= w_chan_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_wr_addr_nxt = r_wr_addr;
        w_chan_nxt    = r_chan;
        w_rd_load     = 1'b0;
        w_rd_base     = '0;
        w_rd_len      = '0;
        w_rd_step     = 1'b0;
        w_rd_wrap     = (r_state == DCONT);
`ifdef SPI_CMD_CTRL_ERR_EN
        w_err_evt     = 1'b0;
        w_err_clr     = 1'b0;
`endif
        if (spi_byte_vld_i) begin
            if (!dc_i) begin
                // Any command byte aborts whatever was in progress.
                w_wr_addr_nxt = '0;
                case (spi_byte_data_i)
                    CONF_WR:  w_state_nxt = CONF;
                    CHAN_SEL: w_state_nxt = CHAN;
                    INFO_RD: begin
                        w_state_nxt = INFO;
                        w_rd_load   = 1'b1;
                        w_rd_len    = INFO_LEN_A;
                    end
                    DATA_RD: begin
                        w_state_nxt = DATA;
                        w_rd_load   = 1'b1;
                        w_rd_base   = w_data_base;
                        w_rd_len    = DATA_LEN_A;
                    end
                    DATA_RD_CONT: begin
                        w_state_nxt = DCONT;
                        w_rd_load   = 1'b1;
                        w_rd_base   = w_data_base;
                        w_rd_len    = DATA_LEN_A;
                    end
`ifdef SPI_CMD_CTRL_ERR_EN
                    ERR_CLR: begin
                        w_state_nxt = IDLE;
                        w_rd_load   = 1'b1;
                        w_err_clr   = 1'b1;
                    end
`endif
                    default: begin
                        w_state_nxt = IDLE;
                        w_rd_load   = 1'b1;
`ifdef SPI_CMD_CTRL_ERR_EN
                        w_err_evt   = 1'b1;
`endif
                    end
                endcase
            end else begin
                case (r_state)
                    CONF: begin
                        if (r_wr_addr == CONF_LAST) begin
                            w_state_nxt   = IDLE;
                            w_wr_addr_nxt = '0;
                        end else begin
                            w_wr_addr_nxt = r_wr_addr + 1'b1;
                        end
                    end
                    CHAN: begin
                        w_state_nxt = IDLE;
                        if ({24'b0, spi_byte_data_i} < 32'(NUM_CH)) begin
                            w_chan_nxt = spi_byte_data_i[CH_W-1:0];
                        end else begin
`ifdef SPI_CMD_CTRL_ERR_EN
                            w_err_evt = 1'b1;
`endif
                        end
                    end
                    INFO, DATA: begin
                        w_rd_step = 1'b1;
                        if (w_rd_last) begin
                            w_state_nxt = IDLE;
                        end
                    end
                    DCONT: w_rd_step = 1'b1;
                    default: begin
                        w_state_nxt   = IDLE;
                        w_wr_addr_nxt = '0;
                        w_rd_load     = 1'b1;
                    end
                endcase
            end
        end
    end

    rd_addr_gen #(
        .RD_AW (RD_AW)
    ) u_rd_addr_gen (
        .i_clk   (clk_i),
        .i_rst_n (rst_n_i),
        .i_load  (w_rd_load),
        .i_base  (w_rd_base),
        .i_len   (w_rd_len),
        .i_step  (w_rd_step),
        .i_wrap  (w_rd_wrap),
        .o_addr  (w_rd_addr),
        .o_last  (w_rd_last)
    );

`ifdef SPI_CMD_CTRL_ERR_EN
    logic       r_err;
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_err_evt) begin
                r_err <= 1'b1;
            end else if (w_err_clr) begin
                r_err <= 1'b0;
            end
            if (w_err_evt && r_err_cnt != 8'hff) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign cmd_err_o = r_err;
    assign err_cnt_o = r_err_cnt;
`else
    assign cmd_err_o = 1'b0;
`endif

    assign reg_wr_en_o   = spi_byte_vld_i & dc_i & (r_state == CONF);
    assign reg_wr_addr_o = r_wr_addr;
    assign reg_rd_addr_o = w_rd_addr;
    assign chan_o        = r_chan;
    assign busy_o        = (r_state != IDLE);

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb/tb_spi_cmd_ctrl.sv - Directed self-checking bench for spi_cmd_ctrl with NUM_CH=2
module tb_spi_cmd_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       dc_i = 1'b0;
    logic       spi_byte_vld_i = 1'b0;
    logic [7:0] spi_byte_data_i = 8'h00;
    logic       reg_wr_en_o;
    logic [1:0] reg_wr_addr_o;
    logic [4:0] reg_rd_addr_o;
    logic [0:0] chan_o;
    logic       busy_o;
    logic       cmd_err_o;
`ifdef SPI_CMD_CTRL_ERR_EN
    logic [7:0] err_cnt_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic       s_wr_en;
    logic [1:0] s_wr_addr;
    logic [4:0] s_rd_addr;

    spi_cmd_ctrl #(
        .NUM_CH (2)
    ) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .dc_i            (dc_i),
        .spi_byte_vld_i  (spi_byte_vld_i),
        .spi_byte_data_i (spi_byte_data_i),
        .reg_wr_en_o     (reg_wr_en_o),
        .reg_wr_addr_o   (reg_wr_addr_o),
        .reg_rd_addr_o   (reg_rd_addr_o),
        .chan_o          (chan_o),
        .busy_o          (busy_o),
        .cmd_err_o       (cmd_err_o)
`ifdef SPI_CMD_CTRL_ERR_EN
        ,
        .err_cnt_o       (err_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Drives one byte for one cycle; s_* hold what the DUT showed while the byte was valid.
    task automatic send(input logic dc, input logic [7:0] b);
        @(negedge clk_i);
        dc_i            = dc;
        spi_byte_data_i = b;
        spi_byte_vld_i  = 1'b1;
        #1;
        s_wr_en   = reg_wr_en_o;
        s_wr_addr = reg_wr_addr_o;
        s_rd_addr = reg_rd_addr_o;
        @(posedge clk_i);
        #1;
        spi_byte_vld_i = 1'b0;
        dc_i           = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        n_vec++;
        if ({reg_wr_en_o, reg_wr_addr_o, reg_rd_addr_o, chan_o, busy_o, cmd_err_o} !== 11'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 0", {reg_wr_en_o, reg_wr_addr_o, reg_rd_addr_o, chan_o, busy_o, cmd_err_o});
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    task automatic test_conf_wr();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        send(1'b0, 8'h2a);
        n_vec++;
        if (busy_o !== 1'b1) begin n_err++; $display("FAIL conf_busy: got %b want 1", busy_o); end
        for (int i = 0; i < 4; i++) begin
            send(1'b1, vals[i]);
            n_vec++;
            if (s_wr_en !== 1'b1 || s_wr_addr !== 2'(i)) begin
                n_err++;
                $display("FAIL conf_write%0d: wr_en=%b addr=%0d want 1/%0d", i, s_wr_en, s_wr_addr, i);
            end
            n_vec++;
            if (busy_o !== (i < 3)) begin
                n_err++;
                $display("FAIL conf_busy%0d: got %b want %b", i, busy_o, (i < 3));
            end
        end
        send(1'b1, 8'h55);
        n_vec++;
        if (s_wr_en !== 1'b0 || reg_wr_addr_o !== 2'd0) begin
            n_err++;
            $display("FAIL conf_extra: wr_en=%b addr=%0d want 0/0", s_wr_en, reg_wr_addr_o);
        end
    endtask

    task automatic test_info_rd();
        send(1'b0, 8'h3a);
        for (int k = 0; k < 7; k++) begin
            send(1'b1, 8'(k));
            n_vec++;
            if (s_rd_addr !== 5'(k)) begin
                n_err++;
                $display("FAIL info_addr%0d: got %0d want %0d", k, s_rd_addr, k);
            end
        end
        n_vec++;
        if (busy_o !== 1'b0 || reg_rd_addr_o !== 5'd0) begin
            n_err++;
            $display("FAIL info_end: busy=%b addr=%0d want 0/0", busy_o, reg_rd_addr_o);
        end
        send(1'b1, 8'h99);
        n_vec++;
        if (s_rd_addr !== 5'd0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL info_byte8: addr=%0d busy=%b want 0/0", s_rd_addr, busy_o);
        end
    endtask

    task automatic test_chan_cont();
        logic [4:0] exp;
        send(1'b0, 8'h2b);
        send(1'b1, 8'h01);
        n_vec++;
        if (chan_o !== 1'b1 || busy_o !== 1'b0 || cmd_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL chan_sel: chan=%b busy=%b err=%b want 1/0/0", chan_o, busy_o, cmd_err_o);
        end
        send(1'b0, 8'h3c);
        for (int i = 0; i < 25; i++) begin
            exp = 5'(19 + (i % 11));
            send(1'b1, 8'(i));
            n_vec++;
            if (s_rd_addr !== exp || busy_o !== 1'b1) begin
                n_err++;
                $display("FAIL cont_addr%0d: addr=%0d busy=%b want %0d/1", i, s_rd_addr, busy_o, exp);
            end
        end
        n_vec++;
        if (reg_rd_addr_o !== 5'd22) begin
            n_err++;
            $display("FAIL cont_final: got %0d want 22", reg_rd_addr_o);
        end
        send(1'b0, 8'h3b);
        for (int i = 0; i < 11; i++) begin
            exp = 5'(19 + i);
            send(1'b1, 8'(i));
            n_vec++;
            if (s_rd_addr !== exp || busy_o !== (i < 10)) begin
                n_err++;
                $display("FAIL data_addr%0d: addr=%0d busy=%b want %0d/%b", i, s_rd_addr, busy_o, exp, (i < 10));
            end
        end
        n_vec++;
        if (reg_rd_addr_o !== 5'd0) begin
            n_err++;
            $display("FAIL data_end: got %0d want 0", reg_rd_addr_o);
        end
    endtask

    task automatic test_chan_err();
        send(1'b0, 8'h2b);
        send(1'b1, 8'h00);
        send(1'b0, 8'h2b);
        send(1'b1, 8'h05);
        n_vec++;
        if (chan_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL chan_bad: chan=%b busy=%b want 0/0", chan_o, busy_o);
        end
`ifdef SPI_CMD_CTRL_ERR_EN
        n_vec++;
        if (cmd_err_o !== 1'b1 || err_cnt_o !== 8'd1) begin
            n_err++;
            $display("FAIL chan_bad_err: flag=%b cnt=%0d want 1/1", cmd_err_o, err_cnt_o);
        end
`else
        n_vec++;
        if (cmd_err_o !== 1'b0) begin n_err++; $display("FAIL chan_bad_err: flag=%b want 0", cmd_err_o); end
`endif
        send(1'b0, 8'h3a);
        send(1'b0, 8'h55);
        n_vec++;
        if (busy_o !== 1'b0 || reg_rd_addr_o !== 5'd0) begin
            n_err++;
            $display("FAIL bad_opcode: busy=%b addr=%0d want 0/0", busy_o, reg_rd_addr_o);
        end
`ifdef SPI_CMD_CTRL_ERR_EN
        n_vec++;
        if (cmd_err_o !== 1'b1 || err_cnt_o !== 8'd2) begin
            n_err++;
            $display("FAIL bad_opcode_err: flag=%b cnt=%0d want 1/2", cmd_err_o, err_cnt_o);
        end
`endif
        send(1'b0, 8'h2f);
        n_vec++;
        if (cmd_err_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL err_clr: flag=%b busy=%b want 0/0", cmd_err_o, busy_o);
        end
    endtask

    task automatic test_abort();
        send(1'b0, 8'h2a);
        send(1'b1, 8'h11);
        n_vec++;
        if (s_wr_en !== 1'b1 || s_wr_addr !== 2'd0) begin
            n_err++;
            $display("FAIL abort_first: wr_en=%b addr=%0d want 1/0", s_wr_en, s_wr_addr);
        end
        send(1'b0, 8'h3a);
        n_vec++;
        if (s_wr_en !== 1'b0 || reg_wr_addr_o !== 2'd0 || reg_rd_addr_o !== 5'd0 || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL abort_cmd: wr_en=%b waddr=%0d raddr=%0d busy=%b want 0/0/0/1", s_wr_en, reg_wr_addr_o, reg_rd_addr_o, busy_o);
        end
        send(1'b1, 8'h22);
        n_vec++;
        if (s_wr_en !== 1'b0 || s_rd_addr !== 5'd0 || reg_rd_addr_o !== 5'd1) begin
            n_err++;
            $display("FAIL abort_info: wr_en=%b addr=%0d next=%0d want 0/0/1", s_wr_en, s_rd_addr, reg_rd_addr_o);
        end
    endtask

    task automatic test_reset_mid();
        send(1'b0, 8'h2a);
        @(negedge clk_i);
        dc_i = 1'b1; spi_byte_data_i = 8'h77; spi_byte_vld_i = 1'b1;
        #1;
        n_vec++;
        if (reg_wr_en_o !== 1'b1) begin n_err++; $display("FAIL pend_write: got %b want 1", reg_wr_en_o); end
        rst_n_i = 1'b0;
        #1;
        n_vec++;
        if (reg_wr_en_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL pend_write_drop: wr_en=%b busy=%b want 0/0", reg_wr_en_o, busy_o);
        end
        spi_byte_vld_i = 1'b0; dc_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        send(1'b0, 8'h2b);
        send(1'b1, 8'h01);
        send(1'b0, 8'h3b);
        repeat (3) send(1'b1, 8'hA5);
        n_vec++;
        if (reg_rd_addr_o !== 5'd22 || chan_o !== 1'b1) begin
            n_err++;
            $display("FAIL mid_burst: addr=%0d chan=%b want 22/1", reg_rd_addr_o, chan_o);
        end
        #2;
        rst_n_i = 1'b0;
        #1;
        n_vec++;
        if ({reg_wr_en_o, reg_wr_addr_o, reg_rd_addr_o, chan_o, busy_o, cmd_err_o} !== 11'b0) begin
            n_err++;
            $display("FAIL async_reset: got %b want 0", {reg_wr_en_o, reg_wr_addr_o, reg_rd_addr_o, chan_o, busy_o, cmd_err_o});
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        send(1'b0, 8'h3b);
        n_vec++;
        if (reg_rd_addr_o !== 5'd8 || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL restart: addr=%0d busy=%b want 8/1", reg_rd_addr_o, busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_conf_wr();
        test_info_rd();
        test_chan_cont();
        test_chan_err();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
